// File: rtl/video_timing.sv
// Raster timing generator: dot/line counters with frame parity, blanking
// decodes and single-cycle event strobes qualified by the dot-clock enable.
module video_timing #(
  parameter int unsigned P_HTOTAL         = 341,
  parameter int unsigned P_VTOTAL         = 262,
  parameter int unsigned P_HVISIBLE       = 256,
  parameter int unsigned P_VVISIBLE       = 240,
  parameter int unsigned P_VBLANK_LINE    = 241,
  parameter int unsigned P_PRERENDER_LINE = 261,
  parameter int unsigned P_ODD_SKIP       = 1
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_enable,
  input  logic        I_render_enable,
  output logic [15:0] O_hcount,
  output logic [15:0] O_vcount,
  output logic        O_not_hblank,
  output logic        O_not_vblank,
  output logic        O_odd_frame,
  output logic [15:0] O_control
);

  localparam logic [15:0] L_LAST_DOT  = 16'(P_HTOTAL - 1);
  localparam logic [15:0] L_SKIP_DOT  = 16'(P_HTOTAL - 2);
  localparam logic [15:0] L_LAST_LINE = 16'(P_VTOTAL - 1);
  localparam logic [15:0] L_HVISIBLE  = 16'(P_HVISIBLE);
  localparam logic [15:0] L_VVISIBLE  = 16'(P_VVISIBLE);
  localparam logic [15:0] L_VBLANK    = 16'(P_VBLANK_LINE);
  localparam logic [15:0] L_PRERENDER = 16'(P_PRERENDER_LINE);

  logic [15:0] hcount_reg, hcount_next;
  logic [15:0] vcount_reg, vcount_next;
  logic        odd_frame_reg, odd_frame_next;
  logic        skip_line;
  logic [15:0] last_dot;
  logic        line_start;

  // Render enable only matters on the odd-frame prerender line, so it is
  // effectively sampled at the candidate skip dot and nowhere else.
  always_comb begin
    skip_line      = (P_ODD_SKIP != 0) && odd_frame_reg && I_render_enable
                     && (vcount_reg == L_PRERENDER);
    last_dot       = skip_line ? L_SKIP_DOT : L_LAST_DOT;
    hcount_next    = hcount_reg;
    vcount_next    = vcount_reg;
    odd_frame_next = odd_frame_reg;
    if (I_enable) begin
      if (hcount_reg >= last_dot) begin
        hcount_next = 16'd0;
        if (vcount_reg >= L_LAST_LINE) begin
          vcount_next    = 16'd0;
          odd_frame_next = ~odd_frame_reg;
        end else begin
          vcount_next = vcount_reg + 16'd1;
        end
      end else begin
        hcount_next = hcount_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      hcount_reg    <= 16'd0;
      vcount_reg    <= 16'd0;
      odd_frame_reg <= 1'b0;
    end else begin
      hcount_reg    <= hcount_next;
      vcount_reg    <= vcount_next;
      odd_frame_reg <= odd_frame_next;
    end
  end

  // Event strobes fire only in enabled cycles so each lasts one dot.
  assign line_start   = I_enable && (hcount_reg == 16'd0);
  assign O_hcount     = hcount_reg;
  assign O_vcount     = vcount_reg;
  assign O_odd_frame  = odd_frame_reg;
  assign O_not_hblank = (hcount_reg < L_HVISIBLE);
  assign O_not_vblank = (vcount_reg < L_VVISIBLE);
  assign O_control    = {11'd0,
                         line_start,
                         line_start && (vcount_reg == 16'd0),
                         (vcount_reg == L_PRERENDER) || O_not_vblank,
                         line_start && (vcount_reg == L_PRERENDER),
                         line_start && (vcount_reg == L_VBLANK)};

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing: two small-raster instances (skip on/off)
// and one default instance, all driven by shared stimulus.
module tb_video_timing;

  logic        clk = 1'b0;
  logic        rst, en, ren;
  logic [15:0] hc  [3];
  logic [15:0] vc  [3];
  logic        nhb [3];
  logic        nvb [3];
  logic        odd [3];
  logic [15:0] ctl [3];

  int ht [3] = '{8, 8, 341};
  int vt [3] = '{5, 5, 262};
  int hv [3] = '{6, 6, 256};
  int vv [3] = '{3, 3, 240};
  int vb [3] = '{3, 3, 241};
  int pr [3] = '{4, 4, 261};
  int sk [3] = '{1, 0, 1};

  int mh [3];
  int mv [3];
  int mo [3];

  logic [32:0] sb_q [$];
  int fs0 [$];
  int fs1 [$];
  int ls0 [$];
  int ls2 [$];
  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  video_timing #(.P_HTOTAL(8), .P_VTOTAL(5), .P_HVISIBLE(6), .P_VVISIBLE(3),
                 .P_VBLANK_LINE(3), .P_PRERENDER_LINE(4), .P_ODD_SKIP(1)) u_small_skip (
    .I_clock(clk), .I_reset(rst), .I_enable(en), .I_render_enable(ren),
    .O_hcount(hc[0]), .O_vcount(vc[0]), .O_not_hblank(nhb[0]), .O_not_vblank(nvb[0]),
    .O_odd_frame(odd[0]), .O_control(ctl[0]));

  video_timing #(.P_HTOTAL(8), .P_VTOTAL(5), .P_HVISIBLE(6), .P_VVISIBLE(3),
                 .P_VBLANK_LINE(3), .P_PRERENDER_LINE(4), .P_ODD_SKIP(0)) u_small_noskip (
    .I_clock(clk), .I_reset(rst), .I_enable(en), .I_render_enable(ren),
    .O_hcount(hc[1]), .O_vcount(vc[1]), .O_not_hblank(nhb[1]), .O_not_vblank(nvb[1]),
    .O_odd_frame(odd[1]), .O_control(ctl[1]));

  video_timing u_default (
    .I_clock(clk), .I_reset(rst), .I_enable(en), .I_render_enable(ren),
    .O_hcount(hc[2]), .O_vcount(vc[2]), .O_not_hblank(nhb[2]), .O_not_vblank(nvb[2]),
    .O_odd_frame(odd[2]), .O_control(ctl[2]));

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_decode(input int i);
    logic ls, nh, nv;
    ls = en && (mh[i] == 0);
    nh = (mh[i] < hv[i]);
    nv = (mv[i] < vv[i]);
    return {14'd0, nh, nv, 11'd0, ls, ls && (mv[i] == 0), (mv[i] == pr[i]) || nv,
            ls && (mv[i] == pr[i]), ls && (mv[i] == vb[i])};
  endfunction

  // Inputs must already be settled; checks decodes, predicts, clocks, checks state.
  task automatic tick();
    logic [32:0] e;
    for (int i = 0; i < 3; i++)
      check_value($sformatf("decode%0d", i), {14'd0, nhb[i], nvb[i], ctl[i]}, exp_decode(i));
    for (int i = 0; i < 3; i++) begin
      int eol;
      if (rst) begin
        mh[i] = 0; mv[i] = 0; mo[i] = 0;
      end else if (en) begin
        eol = ht[i] - 1;
        if (sk[i] != 0 && mo[i] == 1 && ren && mv[i] == pr[i]) eol = ht[i] - 2;
        if (mh[i] < eol) mh[i] = mh[i] + 1;
        else begin
          mh[i] = 0;
          if (mv[i] == vt[i] - 1) begin mv[i] = 0; mo[i] = 1 - mo[i]; end
          else mv[i] = mv[i] + 1;
        end
      end
      sb_q.push_back({16'(mh[i]), 16'(mv[i]), 1'(mo[i])});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = sb_q.pop_front();
      check_value($sformatf("state%0d", i), {15'd0, hc[i], vc[i], odd[i]}, {15'd0, e});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    #1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int found;
    rst = 1'b1; en = 1'b0; ren = 1'b0;
    for (int i = 0; i < 3; i++) begin mh[i] = 0; mv[i] = 0; mo[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_h", {16'd0, hc[2]}, 32'd0);
    check_value("reset_v", {16'd0, vc[2]}, 32'd0);
    check_value("reset_odd", {31'd0, odd[2]}, 32'd0);

    // Constant enable with rendering on: line timing and odd-frame skip.
    do_reset();
    en = 1'b1; ren = 1'b1;
    found = -1;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (ctl[0][3]) fs0.push_back(c);
      if (ctl[1][3]) fs1.push_back(c);
      if (ctl[0][0] && found < 0) found = c;
      if (hc[2] == 16'd255 && vc[2] == 16'd0) check_value("nhb_255", {31'd0, nhb[2]}, 32'd1);
      if (hc[2] == 16'd256 && vc[2] == 16'd0) check_value("nhb_256", {31'd0, nhb[2]}, 32'd0);
      if (c == 341) begin
        check_value("l1_h", {16'd0, hc[2]}, 32'd0);
        check_value("l1_v", {16'd0, vc[2]}, 32'd1);
        check_value("l1_start", {31'd0, ctl[2][4]}, 32'd1);
      end
      tick();
    end
    check_value("vblank_set_cyc", found, 32'd24);
    check_value("fs0_count_ok", {31'd0, fs0.size() >= 5}, 32'd1);
    check_value("fs1_count_ok", {31'd0, fs1.size() >= 4}, 32'd1);
    if (fs0.size() >= 5 && fs1.size() >= 4) begin
      check_value("fs0_first", fs0[0], 32'd0);
      for (int k = 0; k < 4; k++) begin
        check_value($sformatf("frame_len_skip%0d", k), fs0[k+1] - fs0[k], (k % 2 == 0) ? 40 : 39);
      end
      for (int k = 0; k < 3; k++)
        check_value($sformatf("frame_len_noskip%0d", k), fs1[k+1] - fs1[k], 32'd40);
    end

    // Rendering off: no skip even on odd frames.
    do_reset();
    en = 1'b1; ren = 1'b0;
    fs0.delete();
    for (int c = 0; c < 200; c++) begin
      #1;
      if (ctl[0][3]) fs0.push_back(c);
      tick();
    end
    check_value("fs0_norender_count_ok", {31'd0, fs0.size() >= 4}, 32'd1);
    if (fs0.size() >= 4)
      for (int k = 0; k < 3; k++)
        check_value($sformatf("frame_len_norender%0d", k), fs0[k+1] - fs0[k], 32'd40);

    // Enable toggling every cycle: lines stretch to twice the clocks.
    do_reset();
    ren = 1'b1;
    for (int c = 0; c < 700; c++) begin
      en = (c % 2 == 0);
      #1;
      if (ctl[0][4]) ls0.push_back(c);
      if (ctl[2][4]) ls2.push_back(c);
      tick();
    end
    check_value("ls_count_ok", {31'd0, ls0.size() >= 2 && ls2.size() >= 2}, 32'd1);
    if (ls0.size() >= 2 && ls2.size() >= 2) begin
      check_value("line_clocks_small", ls0[1] - ls0[0], 32'd16);
      check_value("line_clocks_default", ls2[1] - ls2[0], 32'd682);
    end

    // Random enable/render with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      ren = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 199) == 0);
      #1;
      tick();
    end
    rst = 1'b0;

    // Mid-frame reset on the default raster at line 100 dot 50.
    do_reset();
    en = 1'b1; ren = 1'b1;
    found = 0;
    for (int c = 0; c < 40000; c++) begin
      #1;
      if (hc[2] == 16'd50 && vc[2] == 16'd100) begin found = 1; break; end
      tick();
    end
    check_value("reach_l100_d50", found, 32'd1);
    rst = 1'b1;
    #1;
    tick();
    check_value("midreset_h", {16'd0, hc[2]}, 32'd0);
    check_value("midreset_v", {16'd0, vc[2]}, 32'd0);
    check_value("midreset_odd", {31'd0, odd[2]}, 32'd0);
    rst = 1'b0;
    #1;
    check_value("midreset_frame_start", {31'd0, ctl[2][3]}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter P_HTOTAL, default 341, meaning dots per line.
REQ-002 SHALL have parameter P_VTOTAL, default 262, meaning lines per frame.
REQ-003 SHALL have parameter P_HVISIBLE, default 256, meaning visible dots per line.
REQ-004 SHALL have parameter P_VVISIBLE, default 240, meaning visible lines per frame.
REQ-005 SHALL have parameter P_VBLANK_LINE, default 241, meaning line on which vblank flag is set.
REQ-006 SHALL have parameter P_PRERENDER_LINE, default 261, meaning line on which vblank flag is cleared.
REQ-007 SHALL have parameter P_ODD_SKIP, default 1, meaning 1 enables the odd-frame short prerender line.
REQ-008 SHALL have port I_clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-009 SHALL have port I_reset, input, 1, meaning reset, synchronous and active-high.
REQ-010 SHALL have port I_enable, input, 1, meaning dot-clock enable; counters advance only when high.
REQ-011 SHALL have port I_render_enable, input, 1, meaning rendering enabled; gates odd-frame skip.
REQ-012 SHALL have port O_hcount, output, 16, meaning current dot.
REQ-013 SHALL have port O_vcount, output, 16, meaning current line.
REQ-014 SHALL have port O_not_hblank, output, 1, meaning high while O_hcount < P_HVISIBLE.
REQ-015 SHALL have port O_not_vblank, output, 1, meaning high while O_vcount < P_VVISIBLE.
REQ-016 SHALL have port O_odd_frame, output, 1, meaning frame parity.
REQ-017 SHALL have port O_control, output, 16, meaning event bits: [0] vblank_set, [1] vblank_clr, [2] is_rendering, [3] frame_start, [4] line_start, [15:5] zero.

Function
REQ-018 SHALL hold O_hcount, O_vcount and O_odd_frame in registers; all other outputs SHALL be combinational decodes of those registers and the inputs (zero latency).
REQ-019 When I_enable=1 and O_hcount < end-of-line dot, O_hcount SHALL increment by 1.
REQ-020 End-of-line dot SHALL be P_HTOTAL-1, except P_HTOTAL-2 when P_ODD_SKIP=1, O_odd_frame=1, I_render_enable=1 and O_vcount=P_PRERENDER_LINE.
REQ-021 At end-of-line dot with I_enable=1, O_hcount SHALL become 0 and O_vcount SHALL increment, wrapping P_VTOTAL-1 -> 0.
REQ-022 On the vcount wrap O_odd_frame SHALL toggle.
REQ-023 I_render_enable SHALL be sampled only at the candidate skip dot (P_HTOTAL-2 of prerender line); changes elsewhere SHALL have no effect on timing.
REQ-024 When I_enable=0 all registers SHALL hold.
REQ-025 O_control[0] SHALL be I_enable & (O_hcount==0) & (O_vcount==P_VBLANK_LINE).
REQ-026 O_control[1] SHALL be I_enable & (O_hcount==0) & (O_vcount==P_PRERENDER_LINE).
REQ-027 O_control[2] SHALL be (O_vcount==P_PRERENDER_LINE) | O_not_vblank, unqualified by I_enable.
REQ-028 O_control[3] SHALL be I_enable & (O_hcount==0) & (O_vcount==0).
REQ-029 O_control[4] SHALL be I_enable & (O_hcount==0).
REQ-030 Each enabled event bit SHALL therefore pulse for exactly one enabled cycle per occurrence.
REQ-031 Counter arithmetic SHALL be 16-bit unsigned; parameters SHALL satisfy P_HVISIBLE < P_HTOTAL <= 65535, P_VVISIBLE <= P_VBLANK_LINE < P_PRERENDER_LINE < P_VTOTAL.

Reset
REQ-032 When I_reset=1 at a clock edge, O_hcount=0, O_vcount=0, O_odd_frame=0 next cycle, regardless of I_enable.
REQ-033 I_reset SHALL take priority over I_enable and any wrap or skip in the same cycle; reset mid-frame SHALL restart at dot 0, line 0, even frame.

Verification
REQ-034 Reset, I_enable=1 constant: after 341 cycles O_hcount=0, O_vcount=1, O_control[4]=1; O_not_hblank falls at hcount 256.
REQ-035 Reset, enable constant, render=1: O_control[0] pulses at cycle 241*341=82181; O_control[1] at 261*341=89001; O_control[2]=0 on lines 240..260.
REQ-036 Render=1: successive frame lengths 89342 (even), 89341 (odd), 89342; with render=0 all frames 89342; P_ODD_SKIP=0 all 89342.
REQ-037 I_enable toggled 1/0 every cycle: counters advance every second cycle; no event bit high in enable-low cycles; line takes 682 clocks.
REQ-038 Reset asserted at line 100 dot 50 while enabled -> next cycle hcount=0, vcount=0, odd=0; frame_start pulses on the next enabled cycle.
REQ-039 Override P_HTOTAL=8, P_VTOTAL=5, P_HVISIBLE=6, P_VVISIBLE=3, P_VBLANK_LINE=3, P_PRERENDER_LINE=4: frame lengths alternate 40/39 with render=1; vblank_set at cycle 24.
